// File: rtl/vga_watch_writer.sv
// vga_watch_writer
//
// On-screen watch engine for the VGA debug path. Every refresh interval it
// snapshots NUM_CH 32-bit probe channels and writes one text row per channel
// into the character display buffer: a change marker ('*' or ' ') followed by
// eight uppercase hex digits, one character per clock.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-high reset
//   ch_data        in   NUM_CH*32 probe bus, channel k at [32k+31:32k]
//   freeze         in   sampled only in the snapshot cycle; keeps the old snapshot
//   display_wen    out  display buffer write enable
//   display_w_addr out  display buffer write address (ADDR_W bits, wraps)
//   display_w_data out  ASCII character
//   busy           out  high from the snapshot cycle through the last write
//   pass_done      out  one-cycle pulse right after the last write
//
// Handshake: the display buffer write port is fire-and-forget. A character is
// transferred on every rising edge where display_wen is high; there is no
// back-pressure. Address and data hold their last values while display_wen is low.

module vga_watch_writer #(
    parameter int NUM_CH         = 8,
    parameter int ADDR_W         = 12,
    parameter int BASE_ADDR      = 0,
    parameter int ROW_STRIDE     = 80,
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH*32-1:0]  ch_data,
    input  logic                  freeze,
    output logic                  display_wen,
    output logic [ADDR_W-1:0]     display_w_addr,
    output logic [7:0]            display_w_data,
    output logic                  busy,
    output logic                  pass_done
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ROW_STRIDE);
    localparam logic [7:0]        STAR     = 8'h2A;
    localparam logic [7:0]        SPACE    = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        // 0-9 -> '0'..'9'; 10-15 -> 'A'..'F' (0x37 + 10 = 0x41)
        if (nib < 4'd10) begin
            hex_char = 8'h30 + {4'h0, nib};
        end else begin
            hex_char = 8'h37 + {4'h0, nib};
        end
    endfunction

    // State and datapath registers
    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [CH_W-1:0]        ch_idx, ch_d;        // channel of the next character to emit
    logic [3:0]             col_idx, col_d;      // column of the next character to emit
    logic [ADDR_W-1:0]      row_addr, row_d;     // buffer address of column 0 of ch_idx
    logic                   last_out, last_d;    // output register holds the final character
    logic [NUM_CH*32-1:0]   shadow, shadow_d;
    logic [NUM_CH-1:0]      chg, chg_d;

    logic                   wen_d, busy_d, done_d;
    logic [ADDR_W-1:0]      addr_d;
    logic [7:0]             data_d;

    // Character source for the WRITE walk
    logic [31:0]            cur_word;
    logic                   cur_chg;
    logic [3:0]             cur_nib;
    logic                   first_chg;

    always_comb begin
        cur_word = '0;
        cur_chg  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx == CH_W'(k)) begin
                cur_word = shadow[k*32 +: 32];
                cur_chg  = chg[k];
            end
        end
        // Column 1 selects bits [31:28], column 8 selects [3:0]; column 0 shifts
        // everything out and is not used for digits.
        cur_nib = 4'(cur_word >> (6'd32 - {col_idx, 2'b00}));
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ch_d     = ch_idx;
        col_d    = col_idx;
        row_d    = row_addr;
        last_d   = last_out;
        shadow_d = shadow;
        chg_d    = chg;
        wen_d    = 1'b0;
        addr_d   = display_w_addr;
        data_d   = display_w_data;
        busy_d   = busy;
        done_d   = 1'b0;

        // The first marker is emitted on the same edge that updates shadow/chg,
        // so it is derived from the live inputs rather than the registers.
        first_chg = !freeze && (ch_data[31:0] != shadow[31:0]);

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (cnt == CNT_LAST) begin
                    state_d = LATCH;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            LATCH: begin
                if (freeze) begin
                    chg_d = '0;
                end else begin
                    shadow_d = ch_data;
                    for (int k = 0; k < NUM_CH; k++) begin
                        chg_d[k] = (ch_data[k*32 +: 32] != shadow[k*32 +: 32]);
                    end
                end
                wen_d   = 1'b1;
                addr_d  = BASE;
                data_d  = first_chg ? STAR : SPACE;
                ch_d    = '0;
                col_d   = 4'd1;
                row_d   = BASE;
                last_d  = 1'b0;
                state_d = WRITE;
            end

            WRITE: begin
                if (last_out) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    wen_d  = 1'b1;
                    addr_d = row_addr + ADDR_W'(col_idx);
                    data_d = (col_idx == 4'd0) ? (cur_chg ? STAR : SPACE) : hex_char(cur_nib);
                    if (col_idx == 4'd8) begin
                        if (ch_idx == CH_LAST) begin
                            last_d = 1'b1;
                        end else begin
                            col_d = 4'd0;
                            ch_d  = ch_idx + 1'b1;
                            row_d = row_addr + STRIDE;
                        end
                    end else begin
                        col_d = col_idx + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            ch_idx         <= '0;
            col_idx        <= '0;
            row_addr       <= '0;
            last_out       <= 1'b0;
            shadow         <= '0;
            chg            <= '0;
            display_wen    <= 1'b0;
            display_w_addr <= '0;
            display_w_data <= '0;
            busy           <= 1'b0;
            pass_done      <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            ch_idx         <= ch_d;
            col_idx        <= col_d;
            row_addr       <= row_d;
            last_out       <= last_d;
            shadow         <= shadow_d;
            chg            <= chg_d;
            display_wen    <= wen_d;
            display_w_addr <= addr_d;
            display_w_data <= data_d;
            busy           <= busy_d;
            pass_done      <= done_d;
        end
    end

endmodule

// File: tb/tb_vga_watch_writer.sv
// Testbench for vga_watch_writer: three channels rendered from base 0xFFC so
// the first row wraps through the top of the 12-bit address space.

module tb_vga_watch_writer;

    localparam int NUM_CH     = 3;
    localparam int ADDR_W     = 12;
    localparam int BASE_ADDR  = 'hFFC;
    localparam int ROW_STRIDE = 80;
    localparam int REFRESH    = 20;
    localparam int NW         = 9 * NUM_CH;
    localparam int PERIOD     = REFRESH + 1 + NW;

    // ---------------- clock / reset / DUT ----------------
    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_CH*32-1:0]  ch_data;
    logic                  freeze;
    logic                  display_wen;
    logic [ADDR_W-1:0]     display_w_addr;
    logic [7:0]            display_w_data;
    logic                  busy;
    logic                  pass_done;

    always #5 clk = ~clk;

    vga_watch_writer #(
        .NUM_CH         (NUM_CH),
        .ADDR_W         (ADDR_W),
        .BASE_ADDR      (BASE_ADDR),
        .ROW_STRIDE     (ROW_STRIDE),
        .REFRESH_CYCLES (REFRESH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_data        (ch_data),
        .freeze         (freeze),
        .display_wen    (display_wen),
        .display_w_addr (display_w_addr),
        .display_w_data (display_w_data),
        .busy           (busy),
        .pass_done      (pass_done)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    // k counts rising edges since reset release; the pass schedule is purely
    // arithmetic: phase = k mod PERIOD, snapshot at phase REFRESH, writes after.
    int           k = -1;
    int           phi;
    logic [31:0]  shadow_m [NUM_CH];
    logic [19:0]  exp_q [$];
    logic [11:0]  last_addr;
    logic [7:0]   last_data;
    int           first_wen_k = -1;
    int           cap_n = 0;
    logic [11:0]  cap_addr [NW];
    logic [7:0]   cap_data [NW];
    string        hexd = "0123456789ABCDEF";
    logic         exp_wen, exp_busy, exp_done, mk;
    logic [19:0]  e;
    logic [31:0]  nv;
    logic [11:0]  a;
    logic [7:0]   d;

    always @(negedge clk) begin : compare
        if (rst) begin
            chk("rst_wen",  display_wen,    0);
            chk("rst_busy", busy,           0);
            chk("rst_done", pass_done,      0);
            chk("rst_addr", display_w_addr, 0);
            chk("rst_data", display_w_data, 0);
            k = -1;
            exp_q.delete();
            for (int c = 0; c < NUM_CH; c++) shadow_m[c] = '0;
            last_addr   = '0;
            last_data   = '0;
            first_wen_k = -1;
            cap_n       = 0;
        end else begin
            k++;
            phi      = k % PERIOD;
            exp_wen  = (phi > REFRESH);
            exp_busy = (phi >= REFRESH);
            exp_done = (k > 0) && (phi == 0);
            if (exp_wen) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL model_queue: no expected write at k=%0d", k);
                end else begin
                    e = exp_q.pop_front();
                    last_addr = e[19:8];
                    last_data = e[7:0];
                end
            end
            chk("wen",       display_wen,    exp_wen);
            chk("busy",      busy,           exp_busy);
            chk("pass_done", pass_done,      exp_done);
            chk("addr",      display_w_addr, last_addr);
            chk("data",      display_w_data, last_data);

            if (display_wen) begin
                if (first_wen_k < 0) first_wen_k = k;
                if (cap_n < NW) begin
                    cap_addr[cap_n] = display_w_addr;
                    cap_data[cap_n] = display_w_data;
                end
                cap_n++;
            end

            if (phi == REFRESH) begin
                // snapshot: the value on the bus right before the capturing edge
                cap_n = 0;
                exp_q.delete();
                for (int c = 0; c < NUM_CH; c++) begin
                    nv = ch_data[c*32 +: 32];
                    if (freeze) begin
                        mk = 1'b0;
                    end else begin
                        mk = (nv != shadow_m[c]);
                        shadow_m[c] = nv;
                    end
                    for (int col = 0; col < 9; col++) begin
                        a = 12'((BASE_ADDR + c * ROW_STRIDE + col) % (1 << ADDR_W));
                        if (col == 0) d = mk ? 8'h2A : 8'h20;
                        else d = hexd[int'((shadow_m[c] >> ((8 - col) * 4)) & 32'hF)];
                        exp_q.push_back({a, d});
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] v);
        ch_data[c*32 +: 32] = v;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(negedge clk);
            if (pass_done) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: pass_done not seen within %0d cycles", name, 4 * PERIOD);
        end
    endtask

    task automatic wait_busy(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: busy not seen within %0d cycles", name, 4 * PERIOD);
        end
    endtask

    task automatic chk_row(input string name, input int idx, input logic [7:0] mark, input string s);
        chk({name, "_mark"}, cap_data[idx], mark);
        for (int i = 0; i < 8; i++) chk({name, "_digit"}, cap_data[idx + 1 + i], s[i]);
    endtask

    // ---------------- stimulus ----------------
    logic [11:0] row0_addr [9];
    int          wc;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        row0_addr = '{12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF, 12'h000,
                      12'h001, 12'h002, 12'h003, 12'h004};
        rst    = 1'b1;
        freeze = 1'b0;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, $urandom);
        repeat (4) begin
            go();
            for (int c = 0; c < NUM_CH; c++) set_ch(c, $urandom);
        end

        // pass 1: literal rows, wrap, first-write timing
        set_ch(0, 32'h1234ABCD);
        set_ch(1, 32'h0);
        set_ch(2, 32'h0);
        go();
        rst = 1'b0;
        wait_done("pass1");
        chk("first_wen_cycle", first_wen_k, REFRESH + 1);
        chk("pass1_wen_count", cap_n, NW);
        for (int i = 0; i < 9; i++) chk("pass1_row0_addr", cap_addr[i], row0_addr[i]);
        chk("pass1_row1_addr_start", cap_addr[9],  12'h04C);
        chk("pass1_row1_addr_end",   cap_addr[17], 12'h054);
        chk("pass1_row2_addr_start", cap_addr[18], 12'h09C);
        chk_row("pass1_row0", 0, 8'h2A, "1234ABCD");
        chk_row("pass1_row1", 9, 8'h20, "00000000");

        // change marker across three passes
        go();
        set_ch(0, 32'hDEADBEEF);
        wait_done("pass2");
        chk_row("pass2_row0", 0, 8'h2A, "DEADBEEF");
        wait_done("pass3");
        chk_row("pass3_row0", 0, 8'h20, "DEADBEEF");
        go();
        set_ch(0, 32'hDEADBEF0);
        wait_done("pass4");
        chk_row("pass4_row0", 0, 8'h2A, "DEADBEF0");

        // freeze keeps the previous snapshot
        go();
        set_ch(0, 32'h11111111);
        wait_done("pass5");
        chk_row("pass5_row0", 0, 8'h2A, "11111111");
        go();
        freeze = 1'b1;
        set_ch(0, 32'h22222222);
        wait_done("pass6");
        chk_row("freeze_row0", 0, 8'h20, "11111111");
        go();
        freeze = 1'b0;
        wait_done("pass7");
        chk_row("unfreeze_row0", 0, 8'h2A, "22222222");

        // coherency: scramble ch0 and freeze during the whole write walk
        go();
        set_ch(0, 32'hCAFEF00D);
        wait_busy("coherent_latch");
        for (int i = 0; i < NW; i++) begin
            go();
            set_ch(0, $urandom);
            freeze = 1'($urandom_range(0, 1));
        end
        go();
        freeze = 1'b0;
        wait_done("coherent");
        chk_row("coherent_row0", 0, 8'h2A, "CAFEF00D");

        // randomized passes, checked cycle by cycle against the model
        for (int cyc = 0; cyc < 6 * PERIOD; cyc++) begin
            go();
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 40) == 0) set_ch(c, $urandom);
            end
            freeze = ($urandom_range(0, 5) == 0);
        end
        go();
        freeze = 1'b0;

        // reset during the fifth write of a pass
        wait_done("pre_reset");
        wait_busy("reset_latch");
        wc = 0;
        for (int i = 0; i < 4 * PERIOD && wc < 5; i++) begin
            @(negedge clk);
            if (display_wen) wc++;
        end
        chk("reached_5th_write", wc, 5);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_wen",  display_wen,    0);
        chk("async_rst_busy", busy,           0);
        chk("async_rst_addr", display_w_addr, 0);
        chk("async_rst_data", display_w_data, 0);
        set_ch(0, 32'h0);
        set_ch(1, 32'h00000001);
        go();
        go();
        rst = 1'b0;
        wait_done("restart");
        chk("restart_first_wen", first_wen_k, REFRESH + 1);
        chk("restart_wen_count", cap_n, NW);
        chk("restart_first_addr", cap_addr[0], 12'hFFC);
        chk_row("restart_row0", 0, 8'h20, "00000000");
        chk_row("restart_row1", 9, 8'h2A, "00000001");
        wait_done("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
